// File: rtl/alu_shr_issue_pkg.sv
// Shared ALU definitions for the right-shifter issue stage.
// Holds the datapath widths, the issue FSM encoding and the shifted-out-bits mask.
package alu_shr_issue_pkg;

    localparam int ALU_W   = 7;
    localparam int SHAMT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } alu_state_e;

    // Mask of the low bits that fall off the bottom for a right shift by shamt.
    function automatic logic [ALU_W-1:0] shr_lost_mask(input logic [SHAMT_W-1:0] shamt);
        logic [ALU_W:0] one_hot;
        one_hot = (ALU_W+1)'(1) << shamt;
        return ALU_W'(one_hot - (ALU_W+1)'(1));
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Small synchronous FIFO holding {data, shift} shift requests.
// Push into a full FIFO or pop from an empty one is ignored.
module alu_req_fifo #(
    parameter  int ENTRY_W = 10,
    parameter  int DEPTH   = 2,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic               pop,
    output logic [ENTRY_W-1:0] rdata,
    output logic [CNT_W-1:0]   count
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign do_push = push && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/alu_shr_issue.sv
// Issue/retire stage around the external 7-bit combinational right shifter:
// request queue -> shifter -> registered response with zero/lost flags.
module alu_shr_issue
    import alu_shr_issue_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_data,
    input  logic [SHAMT_W-1:0] req_shift,
    output logic [WIDTH-1:0]   shf_in,
    output logic [SHAMT_W-1:0] shf_shift,
    input  logic [WIDTH-1:0]   shf_out,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_zero,
    output logic               rsp_lost,
    output logic               busy,
    output logic [7:0]         done_cnt
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = WIDTH + SHAMT_W;

    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   fifo_count;
    logic               q_empty, push, retire, rsp_hs, q_nonempty_d;

    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q;
    logic               rsp_zero_q, rsp_lost_q;
    logic [7:0]         done_cnt_q;
    alu_state_e         state_q, state_d;

    alu_req_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({req_data, req_shift}),
        .pop   (retire),
        .rdata (head),
        .count (fifo_count)
    );

    assign q_empty   = (fifo_count == '0);
    assign req_ready = (fifo_count < CNT_W'(DEPTH));
    assign push      = req_valid && req_ready;
    assign rsp_hs    = rsp_valid_q && rsp_ready;
    assign retire    = !q_empty && (!rsp_valid_q || rsp_ready);

    // Head is gated to zero when empty so the shifter sees a quiet operand.
    assign shf_in    = q_empty ? '0 : head[ENTRY_W-1:SHAMT_W];
    assign shf_shift = q_empty ? '0 : head[SHAMT_W-1:0];

    assign rsp_valid_d  = retire ? 1'b1 : (rsp_hs ? 1'b0 : rsp_valid_q);
    assign q_nonempty_d = push || (fifo_count > CNT_W'(1))
                          || ((fifo_count == CNT_W'(1)) && !retire);

    always_comb begin
        state_d = IDLE;
        if (!q_nonempty_d)
            state_d = rsp_valid_d ? DRAIN : IDLE;
        else if (rsp_valid_d && !rsp_ready)
            state_d = HOLD;
        else
            state_d = RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_lost_q  <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            if (retire) begin
                rsp_data_q <= shf_out;
                rsp_zero_q <= (shf_out == '0);
                rsp_lost_q <= |(shf_in & shr_lost_mask(shf_shift));
            end
            if (rsp_hs) done_cnt_q <= done_cnt_q + 8'd1;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_lost  = rsp_lost_q;
    assign done_cnt  = done_cnt_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_shr_issue.sv
// Directed bench for alu_shr_issue: vector table, back-pressure, reset, streaming.
module tb_alu_shr_issue;
    import alu_shr_issue_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [6:0] req_data = '0;
    logic [2:0] req_shift = '0;
    logic [6:0] shf_in;
    logic [2:0] shf_shift;
    logic [6:0] shf_out;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [6:0] rsp_data;
    logic       rsp_zero;
    logic       rsp_lost;
    logic       busy;
    logic [7:0] done_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Stand-in for the external shifter
    assign shf_out = shf_in >> shf_shift;

    alu_shr_issue #(.WIDTH(7), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_shift (req_shift),
        .shf_in    (shf_in),
        .shf_shift (shf_shift),
        .shf_out   (shf_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_lost  (rsp_lost),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    typedef struct {
        logic [6:0] d;
        logic [2:0] s;
        logic [6:0] ed;
        logic       ez;
        logic       el;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " rsp_data"},  32'(rsp_data),  32'd0);
        chk({tag, " rsp_zero"},  32'(rsp_zero),  32'd0);
        chk({tag, " rsp_lost"},  32'(rsp_lost),  32'd0);
        chk({tag, " busy"},      32'(busy),      32'd0);
        chk({tag, " done_cnt"},  32'(done_cnt),  32'd0);
        chk({tag, " shf_in"},    32'(shf_in),    32'd0);
        chk({tag, " shf_shift"}, 32'(shf_shift), 32'd0);
    endtask

    // Independent reference: lost bits are those pushed past bit 0.
    function automatic logic [8:0] ref_rsp(input logic [6:0] d, input logic [2:0] s);
        logic [6:0]  r;
        logic [13:0] t;
        r = d >> s;
        t = {7'd0, d} << (4'd7 - {1'b0, s});
        return {r, (r == 7'd0), |t[6:0]};
    endfunction

    task automatic push3(input logic [6:0] d0, input logic [2:0] s0,
                         input logic [6:0] d1, input logic [2:0] s1,
                         input logic [6:0] d2, input logic [2:0] s2);
        req_valid = 1'b1;
        req_data = d0; req_shift = s0;
        chk("bp ready 0", 32'(req_ready), 32'd1);
        step();
        req_data = d1; req_shift = s1;
        chk("bp ready 1", 32'(req_ready), 32'd1);
        step();
        req_data = d2; req_shift = s2;
        chk("bp ready 2", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        logic [8:0] expq [$];
        logic [8:0] e;
        int n_rsp, first_c, last_c;

        vecs[0] = '{7'b1011011, 3'd2, 7'b0010110, 1'b0, 1'b1};
        vecs[1] = '{7'b1000000, 3'd6, 7'b0000001, 1'b0, 1'b0};
        vecs[2] = '{7'h7F,      3'd7, 7'h00,      1'b1, 1'b1};
        vecs[3] = '{7'h55,      3'd0, 7'h55,      1'b0, 1'b0};
        vecs[4] = '{7'h01,      3'd1, 7'h00,      1'b1, 1'b1};
        vecs[5] = '{7'h7F,      3'd3, 7'h0F,      1'b0, 1'b1};
        vecs[6] = '{7'h08,      3'd3, 7'h01,      1'b0, 1'b0};
        vecs[7] = '{7'h64,      3'd5, 7'h03,      1'b0, 1'b1};

        step();
        step();
        check_reset("reset");
        rst = 1'b0;

        foreach (vecs[i]) begin
            req_valid = 1'b1;
            req_data  = vecs[i].d;
            req_shift = vecs[i].s;
            chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'd1);
            step();
            req_valid = 1'b0;
            chk($sformatf("v%0d valid early", i), 32'(rsp_valid), 32'd0);
            chk($sformatf("v%0d shf_in", i), 32'(shf_in), 32'(vecs[i].d));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'd1);
            step();
            chk($sformatf("v%0d valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("v%0d data", i), 32'(rsp_data), 32'(vecs[i].ed));
            chk($sformatf("v%0d zero", i), 32'(rsp_zero), 32'(vecs[i].ez));
            chk($sformatf("v%0d lost", i), 32'(rsp_lost), 32'(vecs[i].el));
            step();
            chk($sformatf("v%0d valid clr", i), 32'(rsp_valid), 32'd0);
        end
        chk("table done_cnt", 32'(done_cnt), 32'd8);
        chk("table idle busy", 32'(busy), 32'd0);

        // Back-pressure: queue fills behind a held response
        rsp_ready = 1'b0;
        push3(7'h7E, 3'd1, 7'h03, 3'd1, 7'h50, 3'd4);
        chk("bp full ready", 32'(req_ready), 32'd0);
        chk("bp state", 32'(dut.state_q), 32'(HOLD));
        chk("bp busy", 32'(busy), 32'd1);
        chk("bp hold data", 32'(rsp_data), 32'h3F);
        step();
        step();
        chk("bp stable data", 32'(rsp_data), 32'h3F);
        chk("bp stable lost", 32'(rsp_lost), 32'd0);
        chk("bp stable valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        step();
        chk("bp r1 valid", 32'(rsp_valid), 32'd1);
        chk("bp r1 data", 32'(rsp_data), 32'h01);
        chk("bp r1 lost", 32'(rsp_lost), 32'd1);
        step();
        chk("bp r2 data", 32'(rsp_data), 32'h05);
        chk("bp r2 lost", 32'(rsp_lost), 32'd0);
        step();
        chk("bp end valid", 32'(rsp_valid), 32'd0);
        chk("bp done_cnt", 32'(done_cnt), 32'd11);

        // Reset with a full queue and a pending response
        rsp_ready = 1'b0;
        push3(7'h7F, 3'd1, 7'h11, 3'd2, 7'h22, 3'd3);
        chk("mid full", 32'(req_ready), 32'd0);
        rst = 1'b1;
        step();
        check_reset("midreset");
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("post-reset valid %0d", k), 32'(rsp_valid), 32'd0);
            chk($sformatf("post-reset busy %0d", k), 32'(busy), 32'd0);
        end

        // Streaming at one request per cycle
        n_rsp = 0;
        first_c = -1;
        last_c = -1;
        for (int c = 0; c < 310; c++) begin
            if (c < 300) begin
                req_valid = 1'b1;
                req_data  = 7'($urandom_range(0, 127));
                req_shift = 3'($urandom_range(0, 7));
                chk("stream ready", 32'(req_ready), 32'd1);
                expq.push_back(ref_rsp(req_data, req_shift));
            end else begin
                req_valid = 1'b0;
            end
            step();
            if (rsp_valid) begin
                if (expq.size() == 0) begin
                    chk("stream extra rsp", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("stream rsp", {23'd0, rsp_data, rsp_zero, rsp_lost}, {23'd0, e});
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                n_rsp++;
            end
        end
        chk("stream count", 32'(n_rsp), 32'd300);
        chk("stream one per cycle", 32'(last_c - first_c + 1), 32'd300);
        chk("stream first latency", 32'(first_c), 32'd1);
        chk("stream done_cnt wrap", 32'(done_cnt), 32'd44);
        chk("stream idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
